// File: rtl/asic_wrapper.sv
// AXI-slave fully-connected accelerator tile: streams int8 ifmap/weights and int32 bias
// into 64 int32 accumulators, then returns post-processed results through a read port.
module asic_wrapper (
  input  logic        ACLK,
  input  logic        ARESET,
  output logic        ASIC_interrupt,
  input  logic [7:0]  AWID_S,
  input  logic [31:0] AWADDR_S,
  input  logic [3:0]  AWLEN_S,
  input  logic [2:0]  AWSIZE_S,
  input  logic [1:0]  AWBURST_S,
  input  logic        AWVALID_S,
  output logic        AWREADY_S,
  input  logic [31:0] WDATA_S,
  input  logic [3:0]  WSTRB_S,
  input  logic        WLAST_S,
  input  logic        WVALID_S,
  output logic        WREADY_S,
  output logic [7:0]  BID_S,
  output logic [1:0]  BRESP_S,
  output logic        BVALID_S,
  input  logic        BREADY_S,
  input  logic [7:0]  ARID_S,
  input  logic [31:0] ARADDR_S,
  input  logic [3:0]  ARLEN_S,
  input  logic [2:0]  ARSIZE_S,
  input  logic [1:0]  ARBURST_S,
  input  logic        ARVALID_S,
  output logic        ARREADY_S,
  output logic [7:0]  RID_S,
  output logic [31:0] RDATA_S,
  output logic [1:0]  RRESP_S,
  output logic        RLAST_S,
  output logic        RVALID_S,
  input  logic        RREADY_S
);

  localparam int unsigned N_IN    = 64;
  localparam int unsigned N_OUT   = 64;
  localparam int unsigned CNT_W   = 11;
  localparam int unsigned TILE_W  = 16;
  localparam int unsigned ACC_W   = 32;
  localparam int unsigned SCL_W   = 44;

  localparam logic [15:0]      BASE_HI   = 16'h1004;
  localparam logic [15:0]      OFF_CTRL  = 16'h0000;
  localparam logic [15:0]      OFF_DATA  = 16'h0004;
  localparam logic [15:0]      OFF_OFMAP = 16'h0008;
  localparam logic [1:0]       RESP_OKAY = 2'b00;
  localparam logic [1:0]       RESP_SLV  = 2'b10;
  localparam logic [CNT_W-1:0] W_FIRST   = 11'd16;
  localparam logic [CNT_W-1:0] B_FIRST   = 11'd1040;
  localparam logic [CNT_W-1:0] LAST_T0   = 11'd1103;
  localparam logic [CNT_W-1:0] LAST_TN   = 11'd1039;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_e;
  typedef enum logic       {R_IDLE, R_DATA} rstate_e;

  wstate_e            w_state_q;
  rstate_e            r_state_q;
  logic               awready_q, wready_q, bvalid_q;
  logic [7:0]         bid_q, aw_id_q;
  logic [1:0]         bresp_q;
  logic [31:0]        aw_addr_q;
  logic               arready_q, rvalid_q, rlast_q;
  logic [7:0]         rid_q;
  logic [31:0]        rdata_q;
  logic [1:0]         rresp_q;

  logic [31:0]        ctrl_q;
  logic signed [7:0]  x_q   [N_IN];
  logic [ACC_W-1:0]   acc_q [N_OUT];
  logic [CNT_W-1:0]   load_cnt_q;
  logic [TILE_W-1:0]  tile_q;
  logic [5:0]         rd_ptr_q;
  logic               irq_q;

  logic               wr_fire_c, w_hit_c, w_ok_c, wr_ctrl_c, wr_data_c;
  logic               ar_ready_c, rd_fire_c, r_hit_c, rd_ofmap_c;
  logic [15:0]        w_off_c, r_off_c;
  logic [31:0]        rd_data_c;
  logic [1:0]         rd_resp_c;
  logic               tile_end_c;
  logic [CNT_W-1:0]   w_idx_c;
  logic [5:0]         o_idx_c, k_base_c, b_idx_c;
  logic signed [15:0] prod_c [4];
  logic [ACC_W-1:0]   mac_sum_c;
  logic [ACC_W-1:0]   acc_sel_c, relu_c, ppu_c;
  logic [SCL_W-1:0]   scaled_c, shifted_c;
  logic [7:0]         sat_c;
  logic               unused_c;

  assign unused_c = ^{AWLEN_S, AWSIZE_S, AWBURST_S, WSTRB_S, WLAST_S,
                      ARLEN_S, ARSIZE_S, ARBURST_S};

  // Write-side decode, evaluated on the latched address at the W handshake
  assign wr_fire_c = (w_state_q == W_DATA) && WVALID_S && wready_q;
  assign w_off_c   = aw_addr_q[15:0];
  assign w_hit_c   = (aw_addr_q[31:16] == BASE_HI);
  assign w_ok_c    = w_hit_c && ((w_off_c == OFF_CTRL) || (w_off_c == OFF_DATA) ||
                                 (w_off_c == OFF_OFMAP));
  assign wr_ctrl_c = wr_fire_c && w_hit_c && (w_off_c == OFF_CTRL);
  assign wr_data_c = wr_fire_c && w_hit_c && (w_off_c == OFF_DATA);

  // Reads are only offered while the write side is idle and not being requested
  assign ar_ready_c = arready_q && awready_q && !AWVALID_S;
  assign rd_fire_c  = ARVALID_S && ar_ready_c;
  assign r_off_c    = ARADDR_S[15:0];
  assign r_hit_c    = (ARADDR_S[31:16] == BASE_HI);
  assign rd_ofmap_c = rd_fire_c && r_hit_c && (r_off_c == OFF_OFMAP);

  assign tile_end_c = (tile_q == '0) ? (load_cnt_q == LAST_T0) : (load_cnt_q == LAST_TN);
  assign w_idx_c    = load_cnt_q - W_FIRST;
  assign o_idx_c    = 6'(w_idx_c >> 4);
  assign k_base_c   = {w_idx_c[3:0], 2'b00};
  assign b_idx_c    = 6'(load_cnt_q - B_FIRST);

  // Four signed 8x8 products of one weight word against the matching ifmap bytes
  always_comb begin
    mac_sum_c = '0;
    for (int b = 0; b < 4; b++) begin
      prod_c[b] = x_q[k_base_c + 6'(b)] * $signed(WDATA_S[8*b +: 8]);
      mac_sum_c = mac_sum_c + {{16{prod_c[b][15]}}, prod_c[b]};
    end
  end

  // Post-processing: raw accumulator, or ReLU + unsigned scale + >>16 + clamp to int8
  always_comb begin
    acc_sel_c = acc_q[rd_ptr_q];
    relu_c    = acc_sel_c[ACC_W-1] ? '0 : acc_sel_c;
    scaled_c  = SCL_W'(relu_c) * SCL_W'(ctrl_q[15:4]);
    shifted_c = scaled_c >> 16;
    sat_c     = (shifted_c > SCL_W'(127)) ? 8'd127 : shifted_c[7:0];
    ppu_c     = ctrl_q[0] ? {{24{sat_c[7]}}, sat_c} : acc_sel_c;
  end

  always_comb begin
    rd_data_c = '0;
    rd_resp_c = RESP_SLV;
    if (r_hit_c) begin
      case (r_off_c)
        OFF_CTRL:  begin rd_data_c = ctrl_q;                         rd_resp_c = RESP_OKAY; end
        OFF_DATA:  begin rd_data_c = {irq_q, 20'b0, load_cnt_q};     rd_resp_c = RESP_OKAY; end
        OFF_OFMAP: begin rd_data_c = ppu_c;                          rd_resp_c = RESP_OKAY; end
        default:   begin rd_data_c = '0;                             rd_resp_c = RESP_SLV;  end
      endcase
    end
  end

  // Write channel FSM
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      w_state_q <= W_IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bid_q     <= '0;
      bresp_q   <= '0;
      aw_addr_q <= '0;
      aw_id_q   <= '0;
    end else begin
      case (w_state_q)
        W_IDLE: begin
          awready_q <= 1'b1;
          if (AWVALID_S && awready_q) begin
            aw_addr_q <= AWADDR_S;
            aw_id_q   <= AWID_S;
            awready_q <= 1'b0;
            wready_q  <= 1'b1;
            w_state_q <= W_DATA;
          end
        end
        W_DATA: begin
          if (wr_fire_c) begin
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b1;
            bid_q     <= aw_id_q;
            bresp_q   <= w_ok_c ? RESP_OKAY : RESP_SLV;
            w_state_q <= W_RESP;
          end
        end
        W_RESP: begin
          if (BREADY_S) begin
            bvalid_q  <= 1'b0;
            awready_q <= 1'b1;
            w_state_q <= W_IDLE;
          end
        end
        default: begin
          awready_q <= 1'b0;
          wready_q  <= 1'b0;
          bvalid_q  <= 1'b0;
          w_state_q <= W_IDLE;
        end
      endcase
    end
  end

  // Read channel FSM; RDATA is captured at the AR handshake and held until RREADY
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_state_q <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rid_q     <= '0;
      rdata_q   <= '0;
      rresp_q   <= '0;
    end else begin
      case (r_state_q)
        R_IDLE: begin
          arready_q <= 1'b1;
          if (rd_fire_c) begin
            arready_q <= 1'b0;
            rvalid_q  <= 1'b1;
            rlast_q   <= 1'b1;
            rid_q     <= ARID_S;
            rdata_q   <= rd_data_c;
            rresp_q   <= rd_resp_c;
            r_state_q <= R_DATA;
          end
        end
        R_DATA: begin
          if (RREADY_S) begin
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            arready_q <= 1'b1;
            r_state_q <= R_IDLE;
          end
        end
      endcase
    end
  end

  // Control, stream loading, accumulation and result pointer
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      ctrl_q     <= '0;
      load_cnt_q <= '0;
      tile_q     <= '0;
      rd_ptr_q   <= '0;
      irq_q      <= 1'b0;
      for (int i = 0; i < int'(N_IN); i++)  x_q[i]   <= '0;
      for (int i = 0; i < int'(N_OUT); i++) acc_q[i] <= '0;
    end else if (wr_ctrl_c) begin
      ctrl_q <= WDATA_S;
      irq_q  <= 1'b0;
      if (WDATA_S[3]) begin
        load_cnt_q <= '0;
        tile_q     <= '0;
        rd_ptr_q   <= '0;
        for (int i = 0; i < int'(N_OUT); i++) acc_q[i] <= '0;
      end
    end else if (wr_data_c) begin
      irq_q <= 1'b0;
      if (ctrl_q[3]) begin
        if (load_cnt_q < W_FIRST) begin
          for (int b = 0; b < 4; b++) x_q[{load_cnt_q[3:0], 2'(b)}] <= WDATA_S[8*b +: 8];
        end else if (load_cnt_q < B_FIRST) begin
          acc_q[o_idx_c] <= acc_q[o_idx_c] + mac_sum_c;
        end else begin
          acc_q[b_idx_c] <= acc_q[b_idx_c] + WDATA_S;
        end
        if (tile_end_c) begin
          load_cnt_q <= '0;
          rd_ptr_q   <= '0;
          irq_q      <= 1'b1;
          if (tile_q != '1) tile_q <= tile_q + TILE_W'(1);
        end else begin
          load_cnt_q <= load_cnt_q + CNT_W'(1);
        end
      end
    end else if (rd_ofmap_c) begin
      rd_ptr_q <= rd_ptr_q + 6'd1;
    end
  end

  assign ASIC_interrupt = irq_q;
  assign AWREADY_S      = awready_q;
  assign WREADY_S       = wready_q;
  assign BVALID_S       = bvalid_q;
  assign BID_S          = bid_q;
  assign BRESP_S        = bresp_q;
  assign ARREADY_S      = ar_ready_c;
  assign RVALID_S       = rvalid_q;
  assign RLAST_S        = rlast_q;
  assign RID_S          = rid_q;
  assign RDATA_S        = rdata_q;
  assign RRESP_S        = rresp_q;

endmodule

// File: tb/tb_asic_wrapper.sv
// Directed bench for asic_wrapper: register access, tile streaming, PPU modes,
// error responses and response back-pressure.
module tb_asic_wrapper;

  localparam logic [31:0] A_CTRL  = 32'h1004_0000;
  localparam logic [31:0] A_DATA  = 32'h1004_0004;
  localparam logic [31:0] A_OFMAP = 32'h1004_0008;
  localparam int          TMO     = 50;

  logic        ACLK = 1'b0;
  logic        ARESET = 1'b1;
  logic        ASIC_interrupt;
  logic [7:0]  AWID_S = '0;
  logic [31:0] AWADDR_S = '0;
  logic [3:0]  AWLEN_S = '0;
  logic [2:0]  AWSIZE_S = 3'd2;
  logic [1:0]  AWBURST_S = 2'd1;
  logic        AWVALID_S = 1'b0;
  logic        AWREADY_S;
  logic [31:0] WDATA_S = '0;
  logic [3:0]  WSTRB_S = 4'hF;
  logic        WLAST_S = 1'b1;
  logic        WVALID_S = 1'b0;
  logic        WREADY_S;
  logic [7:0]  BID_S;
  logic [1:0]  BRESP_S;
  logic        BVALID_S;
  logic        BREADY_S = 1'b1;
  logic [7:0]  ARID_S = '0;
  logic [31:0] ARADDR_S = '0;
  logic [3:0]  ARLEN_S = '0;
  logic [2:0]  ARSIZE_S = 3'd2;
  logic [1:0]  ARBURST_S = 2'd1;
  logic        ARVALID_S = 1'b0;
  logic        ARREADY_S;
  logic [7:0]  RID_S;
  logic [31:0] RDATA_S;
  logic [1:0]  RRESP_S;
  logic        RLAST_S;
  logic        RVALID_S;
  logic        RREADY_S = 1'b1;

  int total = 0;
  int bad   = 0;
  int resp_errs = 0;
  logic last_irq_w;

  asic_wrapper dut (
    .ACLK(ACLK), .ARESET(ARESET), .ASIC_interrupt(ASIC_interrupt),
    .AWID_S(AWID_S), .AWADDR_S(AWADDR_S), .AWLEN_S(AWLEN_S), .AWSIZE_S(AWSIZE_S),
    .AWBURST_S(AWBURST_S), .AWVALID_S(AWVALID_S), .AWREADY_S(AWREADY_S),
    .WDATA_S(WDATA_S), .WSTRB_S(WSTRB_S), .WLAST_S(WLAST_S), .WVALID_S(WVALID_S),
    .WREADY_S(WREADY_S),
    .BID_S(BID_S), .BRESP_S(BRESP_S), .BVALID_S(BVALID_S), .BREADY_S(BREADY_S),
    .ARID_S(ARID_S), .ARADDR_S(ARADDR_S), .ARLEN_S(ARLEN_S), .ARSIZE_S(ARSIZE_S),
    .ARBURST_S(ARBURST_S), .ARVALID_S(ARVALID_S), .ARREADY_S(ARREADY_S),
    .RID_S(RID_S), .RDATA_S(RDATA_S), .RRESP_S(RRESP_S), .RLAST_S(RLAST_S),
    .RVALID_S(RVALID_S), .RREADY_S(RREADY_S)
  );

  always #5 ACLK = ~ACLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic timeout(input string tag);
    total++;
    bad++;
    $error("FAIL timeout %s observed=expired expected=handshake", tag);
  endtask

  function automatic logic [31:0] rep(input logic [7:0] v);
    return {v, v, v, v};
  endfunction

  task automatic axi_wr(input logic [31:0] addr, input logic [31:0] data, input logic [7:0] id,
                        input int hold, output logic [1:0] resp, output logic [7:0] bid,
                        output logic irq_w, output int viol);
    int n;
    viol = 0;
    AWADDR_S = addr; AWID_S = id; AWVALID_S = 1'b1;
    #1;
    n = 0;
    while (AWREADY_S !== 1'b1 && n < TMO) begin @(posedge ACLK); #1; n++; end
    if (n >= TMO) timeout("aw");
    @(posedge ACLK); #1;
    AWVALID_S = 1'b0;
    WDATA_S = data; WVALID_S = 1'b1;
    n = 0;
    while (WREADY_S !== 1'b1 && n < TMO) begin @(posedge ACLK); #1; n++; end
    if (n >= TMO) timeout("w");
    @(posedge ACLK); #1;
    WVALID_S = 1'b0;
    irq_w = ASIC_interrupt;
    BREADY_S = (hold == 0);
    n = 0;
    while (BVALID_S !== 1'b1 && n < TMO) begin @(posedge ACLK); #1; n++; end
    if (n >= TMO) timeout("b");
    resp = BRESP_S;
    bid  = BID_S;
    for (int i = 0; i < hold; i++) begin
      @(posedge ACLK); #1;
      if (BVALID_S !== 1'b1 || BRESP_S !== resp || BID_S !== bid ||
          AWREADY_S !== 1'b0 || ARREADY_S !== 1'b0) viol++;
    end
    BREADY_S = 1'b1;
    @(posedge ACLK); #1;
  endtask

  task automatic axi_rd(input logic [31:0] addr, input logic [7:0] id, input int hold,
                        output logic [31:0] data, output logic [1:0] resp,
                        output logic [7:0] rid, output logic rlast, output int viol);
    int n;
    viol = 0;
    ARADDR_S = addr; ARID_S = id; ARVALID_S = 1'b1;
    #1;
    n = 0;
    while (ARREADY_S !== 1'b1 && n < TMO) begin @(posedge ACLK); #1; n++; end
    if (n >= TMO) timeout("ar");
    @(posedge ACLK); #1;
    ARVALID_S = 1'b0;
    RREADY_S = (hold == 0);
    n = 0;
    while (RVALID_S !== 1'b1 && n < TMO) begin @(posedge ACLK); #1; n++; end
    if (n >= TMO) timeout("r");
    data = RDATA_S; resp = RRESP_S; rid = RID_S; rlast = RLAST_S;
    for (int i = 0; i < hold; i++) begin
      @(posedge ACLK); #1;
      if (RVALID_S !== 1'b1 || RDATA_S !== data || RRESP_S !== resp ||
          ARREADY_S !== 1'b0) viol++;
    end
    RREADY_S = 1'b1;
    @(posedge ACLK); #1;
  endtask

  task automatic data_wr(input logic [31:0] d);
    logic [1:0] r; logic [7:0] b; int v;
    axi_wr(A_DATA, d, 8'h11, 0, r, b, last_irq_w, v);
    if (r !== 2'b00) resp_errs++;
  endtask

  task automatic rd(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp);
    logic [7:0] id; logic rl; int v;
    axi_rd(addr, 8'h22, 0, data, resp, id, rl, v);
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data, output logic [1:0] resp);
    logic [7:0] b; logic iw; int v;
    axi_wr(addr, data, 8'h33, 0, resp, b, iw, v);
  endtask

  initial begin
    logic [31:0] d;
    logic [1:0]  r;
    logic [7:0]  id;
    logic        rl, iw;
    int          v;

    // Reset state
    repeat (2) @(posedge ACLK);
    #1;
    check("rst_ready_valid_irq", 32'({AWREADY_S, WREADY_S, BVALID_S, ARREADY_S, RVALID_S,
                                     RLAST_S, ASIC_interrupt}), 32'h0);
    check("rst_bid_bresp_rid_rresp", 32'({BID_S, BRESP_S, RID_S, RRESP_S}), 32'h0);
    check("rst_rdata", RDATA_S, 32'h0);
    ARESET = 1'b0;
    repeat (2) @(posedge ACLK);
    #1;
    check("idle_awready", 32'(AWREADY_S), 32'h1);
    check("idle_arready", 32'(ARREADY_S), 32'h1);
    rd(A_CTRL, d, r);
    check("ctrl_reset_val", d, 32'h0);
    check("ctrl_reset_resp", 32'(r), 32'h0);

    // Write wins over a simultaneous read request
    AWVALID_S = 1'b1; ARVALID_S = 1'b1; AWADDR_S = A_CTRL; ARADDR_S = A_CTRL;
    #1;
    check("aw_ar_same_cycle_arready", 32'(ARREADY_S), 32'h0);
    AWVALID_S = 1'b0;
    #1;
    check("ar_alone_arready", 32'(ARREADY_S), 32'h1);
    ARVALID_S = 1'b0;
    @(posedge ACLK); #1;

    // Single tile, mode 0: x=1, W=2, bias=o -> 128+o
    wr(A_CTRL, 32'h0000_0378, r);
    check("ctrl_wr_resp", 32'(r), 32'h0);
    for (int i = 0; i < 16; i++)   data_wr(rep(8'h01));
    for (int i = 0; i < 1024; i++) data_wr(rep(8'h02));
    for (int i = 0; i < 63; i++)   data_wr(32'(i));
    rd(A_DATA, d, r);
    check("loadcnt_before_last", d, 32'd1103);
    data_wr(32'd63);
    check("irq_after_last_w", 32'(last_irq_w), 32'h1);
    check("irq_level_tile0", 32'(ASIC_interrupt), 32'h1);
    rd(A_DATA, d, r);
    check("status_after_tile0", d, 32'h8000_0000);
    for (int o = 0; o < 64; o++) begin
      axi_rd(A_OFMAP, 8'(o), 0, d, r, id, rl, v);
      check($sformatf("ofmap_t0_%0d", o), d, 32'(128 + o));
      if (o == 5) begin
        check("ofmap_rid", 32'(id), 32'h5);
        check("ofmap_rlast_resp", 32'({rl, r}), 32'h4);
      end
    end
    rd(A_OFMAP, d, r);
    check("ofmap_wrap", d, 32'd128);

    // Error responses leave state untouched
    wr(32'h1004_000C, 32'hFFFF_FFFF, r);
    check("bad_wr_bresp", 32'(r), 32'h2);
    rd(A_CTRL, d, r);
    check("ctrl_after_bad_wr", d, 32'h0000_0378);
    rd(A_DATA, d, r);
    check("status_after_bad_wr", d, 32'h8000_0000);
    rd(32'h2000_0000, d, r);
    check("bad_rd_rresp", 32'(r), 32'h2);
    check("bad_rd_rdata", d, 32'h0);
    rd(32'h1004_0010, d, r);
    check("bad_off_rd", 32'({d[1:0], r}), 32'h2);

    // Two tiles accumulate: -182 + -512 = -694
    wr(A_CTRL, 32'h0000_0008, r);
    check("irq_cleared_by_ctrl", 32'(ASIC_interrupt), 32'h0);
    for (int i = 0; i < 16; i++)   data_wr(rep(8'hFF));
    for (int i = 0; i < 1024; i++) data_wr(rep(8'h03));
    for (int i = 0; i < 64; i++)   data_wr(32'd10);
    check("irq_tile0_of2", 32'(ASIC_interrupt), 32'h1);
    data_wr(rep(8'h02));
    check("irq_drop_tile1", 32'(last_irq_w), 32'h0);
    for (int i = 0; i < 15; i++)   data_wr(rep(8'h02));
    for (int i = 0; i < 1023; i++) data_wr(rep(8'hFC));
    check("irq_before_tile1_end", 32'(ASIC_interrupt), 32'h0);
    data_wr(rep(8'hFC));
    check("irq_tile1_end", 32'(last_irq_w), 32'h1);
    for (int o = 0; o < 64; o++) begin
      rd(A_OFMAP, d, r);
      check($sformatf("ofmap_2t_%0d", o), d, 32'hFFFF_FD4A);
    end

    // DATA write with enable=0 is ignored
    wr(A_CTRL, 32'h0000_0000, r);
    check("irq_clear_ctrl_noen", 32'(ASIC_interrupt), 32'h0);
    data_wr(rep(8'h7F));
    rd(A_DATA, d, r);
    check("loadcnt_disabled", d, 32'h0);
    rd(A_OFMAP, d, r);
    check("acc_kept_disabled", d, 32'hFFFF_FD4A);

    // Mode 1: ReLU, *0x100, >>16, clamp
    wr(A_CTRL, 32'h0000_1009, r);
    for (int i = 0; i < 16; i++)   data_wr(32'h0);
    for (int i = 0; i < 1024; i++) data_wr(rep(8'h05));
    data_wr(32'd5000);
    data_wr(32'hFFFF_FFF9);
    data_wr(32'd1000000);
    data_wr(32'h8000_0000);
    for (int i = 4; i < 64; i++)   data_wr(32'h0);
    check("irq_mode1_tile", 32'(ASIC_interrupt), 32'h1);
    rd(A_OFMAP, d, r);
    check("ppu_5000", d, 32'd19);
    rd(A_OFMAP, d, r);
    check("ppu_neg7", d, 32'd0);
    rd(A_OFMAP, d, r);
    check("ppu_sat127", d, 32'd127);
    rd(A_OFMAP, d, r);
    check("ppu_int_min", d, 32'd0);
    check("data_resp_errs", 32'(resp_errs), 32'h0);

    // Back-pressure on B and R
    axi_wr(A_CTRL, 32'h0000_1001, 8'h5A, 5, r, id, iw, v);
    check("b_hold_viol", 32'(v), 32'h0);
    check("b_hold_bid", 32'(id), 32'h5A);
    check("b_hold_bresp", 32'(r), 32'h0);
    axi_rd(A_CTRL, 8'hA5, 5, d, r, id, rl, v);
    check("r_hold_viol", 32'(v), 32'h0);
    check("r_hold_rid", 32'(id), 32'hA5);
    check("r_hold_data", d, 32'h0000_1001);
    check("after_hold_ready", 32'({AWREADY_S, ARREADY_S}), 32'h3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
